// File: rtl/bit_deserializer_pkg.sv
// bit_deserializer_pkg
//   Shared definitions for the bit deserializer slice: FSM state encodings,
//   the legal WIDTH range used by the elaboration check, and the shift-in
//   helper used to build the next shift-register value.
package bit_deserializer_pkg;

  // FSM encodings kept as plain constants so older code can share them.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Legal word widths.
  localparam int WIDTH_MIN = 32'sd2;
  localparam int WIDTH_MAX = 32'sd32;

  // Shift one bit into a word held in the low 'width' bits of a 32-bit container.
  // msb_first=1: shift left, new bit enters at bit 0, so the first bit ends up at width-1.
  // msb_first=0: shift right, new bit enters at width-1, so the first bit ends up at bit 0.
  // Bits above 'width' must be zero on entry and stay zero on exit.
  function automatic logic [31:0] shift_in(input logic [31:0] cur,
                                           input logic        b,
                                           input int          width,
                                           input logic        msb_first);
    logic [31:0] mask;
    logic [31:0] res;
    if (width >= 32'sd32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    if (msb_first) begin
      res = ((cur << 1) | {31'd0, b}) & mask;
    end else begin
      res = (cur >> 1) | ({31'd0, b} << (width - 32'sd1));
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// bit_deserializer_if
//   Serial input and word output handshake of the bit deserializer.
//   master : the deserializer (consumes the serial bits, drives the word stream)
//   slave  : the environment (drives serial bits and word_ready, consumes words)
//   Signals:
//     bit_in, bit_valid, frame_start : serial bit stream with framing marker
//     word_out, word_valid, word_ready : completed-word valid/ready handshake
interface bit_deserializer_if
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (
    input  bit_in, bit_valid, frame_start, word_ready,
    output word_out, word_valid
  );

  modport slave (
    output bit_in, bit_valid, frame_start, word_ready,
    input  word_out, word_valid
  );
endinterface

// File: rtl/bit_deserializer_word_hold_reg.sv
// word_hold_reg
//   One-entry valid/ready output register for completed words.
//   A load request is accepted when the register is empty or is being
//   drained on the same edge; otherwise the word is dropped and the sticky
//   overflow flag is raised.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     load_req     : a completed word is offered this edge
//     load_data    : the completed word
//     ready        : consumer accepts data when valid
//     clear_flags  : synchronous clear of overflow (a same-edge drop wins)
//     data, valid  : held word and its valid flag
//     overflow     : sticky dropped-word flag
module word_hold_reg
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);

  logic accept_s;
  logic drop_s;
  logic consume_s;

  // Decide whether an offered word fits and whether the held word drains.
  always_comb begin
    accept_s  = load_req && (!valid || ready);
    drop_s    = load_req && valid && !ready;
    consume_s = valid && ready;
  end

  // Held word, valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= {WIDTH{1'b0}};
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept_s) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (consume_s) begin
        // word_out deliberately keeps the consumed value.
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end

      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer
//   Collects a framed serial bit stream into WIDTH-bit words and presents
//   completed words through a one-entry valid/ready output register.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     bus          : serial input + word handshake (master modport)
//     clear_flags  : synchronous clear of overflow and frame_err
//     bit_count    : bits collected in the current partial word (0..WIDTH-1)
//     overflow     : sticky, a completed word was dropped (output register full)
//     frame_err    : sticky, frame_start arrived mid-word (partial word discarded)
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  localparam int  CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  bit_deserializer_if.master bus,
  input  logic             clear_flags,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow,
  output logic             frame_err
);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("bit_deserializer: WIDTH out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_r;
  logic [WIDTH-1:0] shift_r;

  logic [0:0]       state_nxt_s;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] fresh_s;
  logic [WIDTH-1:0] cont_s;
  logic             complete_s;
  logic             ferr_set_s;

  // Candidate shift values: starting a new word from zero, or extending the current one.
  always_comb begin
    fresh_s = WIDTH'(shift_in(32'd0, bus.bit_in, WIDTH, MSB_FIRST));
    cont_s  = WIDTH'(shift_in(32'(shift_r), bus.bit_in, WIDTH, MSB_FIRST));
  end

  // FSM next-state, bit counter and shift register update.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    count_nxt_s = bit_count;
    complete_s  = 1'b0;
    ferr_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.bit_valid && bus.frame_start) begin
          state_nxt_s = ST_COLLECT;
          shift_nxt_s = fresh_s;
          count_nxt_s = CNT_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (bus.bit_valid) begin
          if (bus.frame_start) begin
            // Restart: any partial word is thrown away.
            ferr_set_s  = (bit_count != {CNT_W{1'b0}});
            shift_nxt_s = fresh_s;
            count_nxt_s = CNT_ONE;
          end else if (bit_count == LAST_IDX) begin
            // Last bit of a word: the counter wraps and the next bit starts
            // a new word without needing frame_start.
            shift_nxt_s = cont_s;
            count_nxt_s = {CNT_W{1'b0}};
            complete_s  = 1'b1;
          end else begin
            shift_nxt_s = cont_s;
            count_nxt_s = bit_count + CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        shift_nxt_s = {WIDTH{1'b0}};
        count_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, shift register, bit counter and sticky frame error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bit_count <= {CNT_W{1'b0}};
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_count <= count_nxt_s;
      if (ferr_set_s) begin
        frame_err <= 1'b1;
      end else if (clear_flags) begin
        frame_err <= 1'b0;
      end else begin
        frame_err <= frame_err;
      end
    end
  end

  word_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load_req    (complete_s),
    .load_data   (shift_nxt_s),
    .ready       (bus.word_ready),
    .clear_flags (clear_flags),
    .data        (bus.word_out),
    .valid       (bus.word_valid),
    .overflow    (overflow)
  );

endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer
//   Two instances (MSB-first and LSB-first, WIDTH=8) share one serial stimulus.
//   Expected words are queued when their last bit is driven and checked when
//   the DUT hands them over; table vectors cover back-to-back words, and
//   hand sequences cover overflow, framing errors, same-edge load/consume and reset.
module tb_bit_deserializer;
  import bit_deserializer_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, bit_in, bit_valid, frame_start, word_ready, clear_flags;
  logic [3:0] cnt_m, cnt_l;
  logic ovf_m, ovf_l, ferr_m, ferr_l;

  bit_deserializer_if #(.WIDTH(W)) bus_m ();
  bit_deserializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.bit_in      = bit_in;
  assign bus_m.bit_valid   = bit_valid;
  assign bus_m.frame_start = frame_start;
  assign bus_m.word_ready  = word_ready;
  assign bus_l.bit_in      = bit_in;
  assign bus_l.bit_valid   = bit_valid;
  assign bus_l.frame_start = frame_start;
  assign bus_l.word_ready  = word_ready;

  bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bus(bus_m), .clear_flags(clear_flags),
    .bit_count(cnt_m), .overflow(ovf_m), .frame_err(ferr_m)
  );

  bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bus(bus_l), .clear_flags(clear_flags),
    .bit_count(cnt_l), .overflow(ovf_l), .frame_err(ferr_l)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  typedef struct {
    logic [7:0] seq;   // seq[7] is sent first
    logic [7:0] e_m;   // expected word, MSB-first instance
    logic [7:0] e_l;   // expected word, LSB-first instance
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && bus_m.word_valid && word_ready) begin
      if (q_m.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_m: unexpected word %0h, expected none", bus_m.word_out);
      end else begin
        e = q_m.pop_front();
        check("sb_m word", 32'(bus_m.word_out), 32'(e));
      end
    end
    if (!reset && bus_l.word_valid && word_ready) begin
      if (q_l.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_l: unexpected word %0h, expected none", bus_l.word_out);
      end else begin
        e = q_l.pop_front();
        check("sb_l word", 32'(bus_l.word_out), 32'(e));
      end
    end
  end

  task automatic step(input logic bv, input logic fs, input logic b,
                      input logic rdy, input logic clr);
    bit_valid   = bv;
    frame_start = fs;
    bit_in      = b;
    word_ready  = rdy;
    clear_flags = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] seq, input logic [7:0] e_m, input logic [7:0] e_l,
                           input logic fs, input logic rd_mid, input logic rd_last,
                           input logic clr_last, input logic load);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && load) begin
        q_m.push_back(e_m);
        q_l.push_back(e_l);
      end
      step(1'b1, (i == 7) ? fs : 1'b0, seq[i], (i == 0) ? rd_last : rd_mid,
           (i == 0) ? clr_last : 1'b0);
    end
  endtask

  initial begin
    logic [7:0] s;

    vecs[0] = '{seq: 8'hFF, e_m: 8'hFF, e_l: 8'hFF};
    vecs[1] = '{seq: 8'h01, e_m: 8'h01, e_l: 8'h80};
    vecs[2] = '{seq: 8'h1E, e_m: 8'h1E, e_l: 8'h78};
    vecs[3] = '{seq: 8'hC4, e_m: 8'hC4, e_l: 8'h23};
    vecs[4] = '{seq: 8'h6A, e_m: 8'h6A, e_l: 8'h56};

    // Reset state
    reset = 1'b1;
    bit_valid = 1'b0; frame_start = 1'b0; bit_in = 1'b0;
    word_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst bit_count", 32'(cnt_m), 32'd0);
    check("rst word_out", 32'(bus_m.word_out), 32'd0);
    check("rst word_valid", 32'(bus_m.word_valid), 32'd0);
    check("rst overflow", 32'(ovf_m), 32'd0);
    check("rst frame_err", 32'(ferr_m), 32'd0);
    reset = 1'b0;
    idle(2, 1'b1);

    // Test 1/2: bits 1,0,1,1,0,0,1,0 -> B2 (MSB first) / 4D (LSB first), latency 1
    s = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        q_m.push_back(8'hB2);
        q_l.push_back(8'h4D);
      end
      step(1'b1, (i == 0), s[7 - i], 1'b1, 1'b0);
      if (i == 6) check("t1 valid before last", 32'(bus_m.word_valid), 32'd0);
      if (i == 2) check("t1 bit_count", 32'(cnt_m), 32'd3);
    end
    check("t1 valid", 32'(bus_m.word_valid), 32'd1);
    check("t1 word msb", 32'(bus_m.word_out), 32'hB2);
    check("t2 word lsb", 32'(bus_l.word_out), 32'h4D);
    check("t1 bit_count wrap", 32'(cnt_m), 32'd0);
    idle(1, 1'b1);
    check("t1 valid one cycle", 32'(bus_m.word_valid), 32'd0);
    check("t1 word held", 32'(bus_m.word_out), 32'hB2);

    // Table: back-to-back words, continuation without frame_start
    for (int k = 0; k < 5; k++) begin
      send_word(vecs[k].seq, vecs[k].e_m, vecs[k].e_l, (k == 0), 1'b1, 1'b1, 1'b0, 1'b1);
      check("vec word msb", 32'(bus_m.word_out), 32'(vecs[k].e_m));
      check("vec word lsb", 32'(bus_l.word_out), 32'(vecs[k].e_l));
      check("vec valid", 32'(bus_m.word_valid), 32'd1);
    end
    idle(2, 1'b1);
    check("vec frame_err", 32'(ferr_m), 32'd0);
    check("vec overflow", 32'(ovf_m), 32'd0);

    // Test 3: overflow with word_ready=0, clear, and set-wins-over-clear
    send_word(8'hB2, 8'hB2, 8'h4D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3 first valid", 32'(bus_m.word_valid), 32'd1);
    send_word(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3 overflow", 32'(ovf_m), 32'd1);
    check("t3 word kept", 32'(bus_m.word_out), 32'hB2);
    check("t3 valid kept", 32'(bus_m.word_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3 overflow cleared", 32'(ovf_m), 32'd0);
    send_word(8'h01, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3 set wins clear", 32'(ovf_m), 32'd1);
    check("t3 word kept 2", 32'(bus_m.word_out), 32'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3 overflow cleared 2", 32'(ovf_m), 32'd0);
    idle(1, 1'b1);
    check("t3 drained", 32'(bus_m.word_valid), 32'd0);

    // Test 4: 3 bits, then frame_start with A5
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4 bit_count 3", 32'(cnt_m), 32'd3);
    check("t4 no frame_err yet", 32'(ferr_m), 32'd0);
    s = 8'hA5;
    step(1'b1, 1'b1, s[7], 1'b0, 1'b0);
    check("t4 bit_count 1", 32'(cnt_m), 32'd1);
    check("t4 frame_err", 32'(ferr_m), 32'd1);
    for (int i = 6; i >= 0; i--) begin
      if (i == 0) begin
        q_m.push_back(8'hA5);
        q_l.push_back(8'hA5);
      end
      step(1'b1, 1'b0, s[i], 1'b0, 1'b0);
    end
    check("t4 word msb", 32'(bus_m.word_out), 32'hA5);
    check("t4 word lsb", 32'(bus_l.word_out), 32'hA5);
    check("t4 valid", 32'(bus_m.word_valid), 32'd1);

    // Test 5: consume A5 on the same edge the next word completes
    send_word(8'hC4, 8'hC4, 8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t5 valid stays", 32'(bus_m.word_valid), 32'd1);
    check("t5 word msb", 32'(bus_m.word_out), 32'hC4);
    check("t5 word lsb", 32'(bus_l.word_out), 32'h23);
    check("t5 no overflow", 32'(ovf_m), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5 frame_err cleared", 32'(ferr_m), 32'd0);

    // Test 6: reset mid-word with a pending word
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
    check("t6 bit_count 5", 32'(cnt_m), 32'd5);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    q_m.delete();
    q_l.delete();
    check("t6 bit_count", 32'(cnt_m), 32'd0);
    check("t6 valid", 32'(bus_m.word_valid), 32'd0);
    check("t6 word_out", 32'(bus_m.word_out), 32'd0);
    check("t6 overflow", 32'(ovf_m), 32'd0);
    check("t6 frame_err", 32'(ferr_m), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("t6 idle ignores bits", 32'(cnt_m), 32'd0);
    end
    check("t6 valid after bits", 32'(bus_m.word_valid), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6 frame_start w/o valid", 32'(cnt_m), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6 restart", 32'(cnt_m), 32'd1);
    check("t6 no frame_err", 32'(ferr_m), 32'd0);

    idle(2, 1'b1);
    check("sb_m empty", 32'(q_m.size()), 32'd0);
    check("sb_l empty", 32'(q_l.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
